// File: rtl/bp_fpga_host_pkg.sv
// Shared FPGA host definitions: NBF packet width/layout macros, the default
// BlackParrot address/data widths, and the NBF opcode set.

`ifndef BP_FPGA_HOST_PKG_SV
`define BP_FPGA_HOST_PKG_SV

// Total NBF packet width: one opcode byte, then the address, then the data.
`define BP_FPGA_HOST_NBF_WIDTH(addr_width_mp, data_width_mp) \
  (8 + (addr_width_mp) + (data_width_mp))

// NBF packet layout. The opcode sits in the low byte so the byte stream
// starts with it when the packet is shifted out LSB first.
`define DECLARE_BP_FPGA_HOST_NBF_S(addr_width_mp, data_width_mp) \
  typedef struct packed { \
    logic [(data_width_mp)-1:0] data; \
    logic [(addr_width_mp)-1:0] addr; \
    logic [7:0]                 opcode; \
  } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

  // Default BlackParrot configuration widths.
  localparam int paddr_width_gp = 40;
  localparam int dword_width_gp = 64;

  typedef enum logic [7:0] {
    e_nbf_write_1 = 8'h00,
    e_nbf_write_2 = 8'h01,
    e_nbf_write_4 = 8'h02,
    e_nbf_write_8 = 8'h03,
    e_nbf_read_8  = 8'h13,
    e_nbf_fence   = 8'hFE,
    e_nbf_finish  = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

  // Number of whole bytes in a field of the given bit width.
  function automatic int nbf_bytes(input int width_bits);
    return width_bits / 8;
  endfunction

endpackage

`endif

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear. Clear wins over up; the count saturates
// at nothing, so the caller must keep it below max_val_p.

module bsg_counter_clear_up #(
  parameter  int max_val_p  = 14,
  parameter  int init_val_p = 0,
  localparam int width_lp   = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  // Count register: reset to init, clear to zero, otherwise step on up_i.
  // NOTE: sequential state uses non-blocking assignments so every flop in
  // the design samples the pre-edge values, independent of block order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= width_lp'(init_val_p);
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i) begin
      count_o <= count_o + width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_fpga_host_nbf_piso.sv
// NBF packet parallel-in/serial-out stage. Accepts one packet on a
// ready/valid handshake and emits it as bytes on a valid/yumi handshake:
// opcode, then address little-endian, then data little-endian.

module bp_fpga_host_nbf_piso
  import bp_fpga_host_pkg::*;
#(
  parameter  int nbf_addr_width_p = paddr_width_gp,
  parameter  int nbf_data_width_p = dword_width_gp,
  localparam int nbf_width_lp     = `BP_FPGA_HOST_NBF_WIDTH(nbf_addr_width_p, nbf_data_width_p),
  localparam int nbf_bytes_lp     = nbf_bytes(nbf_width_lp),
  localparam int count_width_lp   = $clog2(nbf_bytes_lp + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [nbf_width_lp-1:0] nbf_i,
  input  logic                    nbf_v_i,
  output logic                    nbf_ready_and_o,

  output logic [7:0]              tx_data_o,
  output logic                    tx_v_o,
  input  logic                    tx_yumi_i,

  output logic                    busy_o
);

  localparam logic [0:0] e_ready = 1'b0;
  localparam logic [0:0] e_send  = 1'b1;

  localparam logic [count_width_lp-1:0] last_count_lp = count_width_lp'(nbf_bytes_lp - 1);

  logic [0:0]                state_r;
  logic [nbf_width_lp-1:0]   shift_r;
  logic [count_width_lp-1:0] count_r;

  logic accept;
  logic consume;
  logic last_byte;

  assign accept    = (state_r == e_ready) & nbf_v_i;
  assign consume   = (state_r == e_send) & tx_yumi_i;
  assign last_byte = (count_r == last_count_lp);

  // Byte index within the packet being sent.
  bsg_counter_clear_up #(
    .max_val_p  (nbf_bytes_lp),
    .init_val_p (0)
  ) byte_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (accept),
    .up_i    (consume),
    .count_o (count_r)
  );

  // FSM and shift register: latch on accept, shift one byte per yumi,
  // return to ready after the final byte is consumed.
  // NOTE: the shift register is reset along with the state so tx_data_o
  // reads zero out of reset and a reset mid-packet leaves no stale bytes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      shift_r <= '0;
    end else if (state_r == e_ready) begin
      if (nbf_v_i) begin
        shift_r <= nbf_i;
        state_r <= e_send;
      end
    end else begin
      if (tx_yumi_i) begin
        shift_r <= {8'h00, shift_r[nbf_width_lp-1:8]};
        if (last_byte) begin
          state_r <= e_ready;
        end
      end
    end
  end

  // Outputs come straight from registers or the state decode, so neither
  // handshake input has a combinational path to any output.
  assign nbf_ready_and_o = (state_r == e_ready);
  assign tx_v_o          = (state_r == e_send);
  assign busy_o          = tx_v_o;
  assign tx_data_o       = shift_r[7:0];

  // Yumi without a byte on offer is a transmitter bug; the FSM ignores it.
  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) !(tx_yumi_i && !tx_v_o)
  ) else $error("tx_yumi_i asserted while tx_v_o low");

endmodule
